vga_timing_pipe: RTL and testbench

- Parametrised VGA timing generator and pixel output pipeline. It is the successor of the fixed 640x480 vga_ctrl.
- Drives h_addr/v_addr to a framebuffer, which may be a registered or multi-cycle memory.
- Re-aligns sync/blank with the returned pixel data over a configurable read latency.
- Adds pixel-enable clock division, line/frame strobes and a frame counter; sits between the vmem-style framebuffer and the VGA pins in top.

---
 rtl/vga_timing_pipe.sv | 260 ++++++++++++++++++++++++++
 tb/tb_vga_timing_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// vga_timing_pipe
//   Parametrised VGA timing generator with a latency-aligned pixel output
//   stage. Presents column/line addresses to a framebuffer whose read data
//   returns RD_LATENCY enabled cycles later, and delays sync/blank by the
//   same amount so that the pins stay mutually aligned. One extra output
//   register stage follows, giving RD_LATENCY+1 enabled cycles from
//   h_addr to the pins.
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   When defined, adds input pat_sel. With pat_sel=1 the colours come from
//   an internal 8-bar pattern, vga_data is ignored and rd_en is held low.
//
// Ports
//   clk          in   pixel-domain clock
//   rst          in   synchronous active-high reset (overrides pix_en)
//   pix_en       in   pixel advance enable (tie 1 for full rate)
//   vga_data     in   {R,G,B} from framebuffer, RD_LATENCY enabled cycles
//                     after the address
//   pat_sel      in   test-pattern select (VGA_TEST_PATTERN_EN only)
//   h_addr       out  current column, 0 outside the active region
//   v_addr       out  current line, 0 outside the active region
//   rd_en        out  address valid (active region and pix_en)
//   hsync        out  horizontal sync, latency-aligned, polarity HSYNC_POL
//   vsync        out  vertical sync, latency-aligned, polarity VSYNC_POL
//   valid        out  active video (blank_n), latency-aligned
//   vga_r/g/b    out  colour outputs, 0 while blanked
//   line_start   out  one-cycle pulse at h_cnt=0
//   frame_start  out  one-cycle pulse at h_cnt=0, v_cnt=0
//   frame_cnt    out  completed-frame counter (wraps at 16 bits)
// ---------------------------------------------------------------------------
module vga_timing_pipe #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int RD_LATENCY = 1,
  parameter int AW_H       = 10,
  parameter int AW_V       = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_en,
  input  logic [23:0]     vga_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic            pat_sel,
`endif
  output logic [AW_H-1:0] h_addr,
  output logic [AW_V-1:0] v_addr,
  output logic            rd_en,
  output logic            hsync,
  output logic            vsync,
  output logic            valid,
  output logic [7:0]      vga_r,
  output logic [7:0]      vga_g,
  output logic [7:0]      vga_b,
  output logic            line_start,
  output logic            frame_start,
  output logic [15:0]     frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  // All boundaries are strictly below the totals, so they fit the counter widths.
  localparam logic [HCW-1:0] L_H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] L_H_ACT    = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] L_HS_BEG   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] L_HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] L_V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] L_V_ACT    = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] L_VS_BEG   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] L_VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic L_HS_ON = (HSYNC_POL != 0);
  localparam logic L_VS_ON = (VSYNC_POL != 0);

  if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
      (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_timing
    $error("vga_timing_pipe: porch and sync widths must be non-zero");
  end
  if ((64'(H_ACTIVE) > (64'd1 << AW_H)) || (64'(V_ACTIVE) > (64'd1 << AW_V))) begin : g_bad_aw
    $error("vga_timing_pipe: active area does not fit the address width");
  end
  if ((RD_LATENCY < 0) || (RD_LATENCY > 7)) begin : g_bad_lat
    $error("vga_timing_pipe: RD_LATENCY must be within 0..7");
  end

  // -------------------------------------------------------------------------
  // Timing counters
  // -------------------------------------------------------------------------
  logic [HCW-1:0] r_hcnt;
  logic [VCW-1:0] r_vcnt;
  logic [15:0]    r_frame_cnt;
  logic           w_h_last;
  logic           w_v_last;

  assign w_h_last = (r_hcnt == L_H_LAST);
  assign w_v_last = (r_vcnt == L_V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_frame_cnt <= '0;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
      if (w_h_last && w_v_last) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Raw timing decode and framebuffer addressing
  // -------------------------------------------------------------------------
  logic w_act;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_rd_ok;

  assign w_act    = (r_hcnt < L_H_ACT) && (r_vcnt < L_V_ACT);
  assign w_hs_raw = (r_hcnt >= L_HS_BEG) && (r_hcnt < L_HS_END);
  assign w_vs_raw = (r_vcnt >= L_VS_BEG) && (r_vcnt < L_VS_END);

`ifdef VGA_TEST_PATTERN_EN
  assign w_rd_ok = ~pat_sel;
`else
  assign w_rd_ok = 1'b1;
`endif

  assign h_addr = w_act ? AW_H'(r_hcnt) : '0;
  assign v_addr = w_act ? AW_V'(r_vcnt) : '0;
  // Reads are held off while reset is asserted; the counters are not yet valid.
  assign rd_en  = w_act & pix_en & ~rst & w_rd_ok;

  assign line_start  = pix_en & ~rst & (r_hcnt == '0);
  assign frame_start = pix_en & ~rst & (r_hcnt == '0) & (r_vcnt == '0);
  assign frame_cnt   = r_frame_cnt;

  // -------------------------------------------------------------------------
  // Alignment pipeline: sync/blank travel alongside the framebuffer read
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic            hs;
    logic            vs;
    logic            act;
`ifdef VGA_TEST_PATTERN_EN
    logic [AW_H-1:0] haddr;
`endif
  } stage_t;

  localparam stage_t STAGE_IDLE = '0;

  stage_t w_raw;
  stage_t w_dly;

  always_comb begin
    w_raw     = STAGE_IDLE;
    w_raw.hs  = w_hs_raw;
    w_raw.vs  = w_vs_raw;
    w_raw.act = w_act;
`ifdef VGA_TEST_PATTERN_EN
    w_raw.haddr = h_addr;
`endif
  end

  if (RD_LATENCY == 0) begin : g_lat0
    assign w_dly = w_raw;
  end else begin : g_latn
    stage_t r_pipe [RD_LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
          r_pipe[i] <= STAGE_IDLE;
        end
      end else if (pix_en) begin
        r_pipe[0] <= w_raw;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign w_dly = r_pipe[RD_LATENCY-1];
  end

  // -------------------------------------------------------------------------
  // Colour source selection
  // -------------------------------------------------------------------------
  logic [23:0] w_rgb_nxt;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BW = AW_H + 4;

  logic [BW-1:0] w_bar_num;
  logic [2:0]    w_bar;
  logic [23:0]   w_pat_rgb;

  // Bar index = column * 8 / H_ACTIVE, always below 8 inside the active area.
  assign w_bar_num = BW'(w_dly.haddr) << 3;
  assign w_bar     = 3'(w_bar_num / BW'(H_ACTIVE));
  assign w_pat_rgb = {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
`endif

  always_comb begin
    w_rgb_nxt = '0;
    if (w_dly.act) begin
`ifdef VGA_TEST_PATTERN_EN
      w_rgb_nxt = pat_sel ? w_pat_rgb : vga_data;
`else
      w_rgb_nxt = vga_data;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Output register: one stage for colours and sync/blank together
  // -------------------------------------------------------------------------
  logic        r_hsync;
  logic        r_vsync;
  logic        r_valid;
  logic [23:0] r_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync <= ~L_HS_ON;
      r_vsync <= ~L_VS_ON;
      r_valid <= 1'b0;
      r_rgb   <= '0;
    end else if (pix_en) begin
      r_hsync <= w_dly.hs ? L_HS_ON : ~L_HS_ON;
      r_vsync <= w_dly.vs ? L_VS_ON : ~L_VS_ON;
      r_valid <= w_dly.act;
      r_rgb   <= w_rgb_nxt;
    end
  end

  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign valid = r_valid;
  assign vga_r = r_rgb[23:16];
  assign vga_g = r_rgb[15:8];
  assign vga_b = r_rgb[7:0];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_pipe
//   Two instances on a 16x8 total raster (8x4 visible):
//     u_dut0 : RD_LATENCY=2, active-low syncs, fed by a 2-cycle framebuffer
//     u_dut1 : RD_LATENCY=0, active-high syncs, fed combinationally
//   A raster-position reference model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_vga_timing_pipe;

  localparam int HT    = 16;
  localparam int VT    = 8;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [23:0] vga_data0, vga_data1;

  logic [7:0]  h_addr0, v_addr0, h_addr1, v_addr1;
  logic        rd_en0, hsync0, vsync0, valid0, ls0, fs0;
  logic        rd_en1, hsync1, vsync1, valid1, ls1, fs1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic [15:0] fc0, fc1;

  always #5 clk = ~clk;

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(0), .RD_LATENCY(2), .AW_H(8), .AW_V(8)
  ) u_dut0 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vga_data(vga_data0),
    .h_addr(h_addr0), .v_addr(v_addr0), .rd_en(rd_en0),
    .hsync(hsync0), .vsync(vsync0), .valid(valid0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
  );

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .RD_LATENCY(0), .AW_H(8), .AW_V(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vga_data(vga_data1),
    .h_addr(h_addr1), .v_addr(v_addr1), .rd_en(rd_en1),
    .hsync(hsync1), .vsync(vsync1), .valid(valid1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
  );

  typedef struct packed {
    logic [7:0]  ha;
    logic [7:0]  va;
    logic        rd;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
    logic        hs;
    logic        vs;
    logic        vl;
    logic [23:0] rgb;
  } obs_t;

  obs_t exp_q0[$];
  obs_t exp_q1[$];

  int tests = 0;
  int fails = 0;

  // Reference model: raster position, frame count, and per-instance queues of
  // positions in flight towards the pins (-1 marks a cleared pipeline slot).
  int          pos;
  int          frame;
  int          pq0[$];
  int          pq1[$];
  int          out0, out1;
  logic [23:0] orgb0, orgb1;
  bit          model_ok = 1'b0;
  bit          blank_mode = 1'b0;
  logic [15:0] fb1, fb2;

  function automatic bit is_active(int p);
    return ((p % HT) < 8) && ((p / HT) < 4);
  endfunction

  function automatic logic [23:0] pixel_of(int p);
    if (p < 0 || !is_active(p)) return 24'h0;
    if (blank_mode) return 24'hFFFFFF;
    return {8'(p % HT), 8'(p / HT), 8'h5A};
  endfunction

  function automatic obs_t expect_obs(int o, logic [23:0] orgb, bit pol_hi, logic r, logic en);
    obs_t e;
    int   h, v, oh, ov;
    bit   act;
    h   = pos % HT;
    v   = pos / HT;
    act = is_active(pos);
    e.ha = act ? 8'(h) : 8'h0;
    e.va = act ? 8'(v) : 8'h0;
    e.rd = act && en && !r;
    e.ls = en && !r && (h == 0);
    e.fs = en && !r && (pos == 0);
    e.fc = 16'(frame);
    if (o < 0) begin
      e.hs = !pol_hi;
      e.vs = !pol_hi;
      e.vl = 1'b0;
    end else begin
      oh   = o % HT;
      ov   = o / HT;
      e.hs = (oh >= 10 && oh < 13) ? pol_hi : !pol_hi;
      e.vs = (ov >= 5 && ov < 7) ? pol_hi : !pol_hi;
      e.vl = is_active(o);
    end
    e.rgb = orgb;
    return e;
  endfunction

  task automatic model_edge(input logic r, input logic en, input logic [15:0] a);
    if (r) begin
      pos   = 0;
      frame = 0;
      pq0.delete();
      pq0.push_back(-1);
      pq0.push_back(-1);
      pq1.delete();
      out0  = -1;
      out1  = -1;
      orgb0 = '0;
      orgb1 = '0;
      model_ok = 1'b1;
    end else if (en && model_ok) begin
      pq0.push_back(pos);
      out0  = pq0.pop_front();
      orgb0 = pixel_of(out0);
      pq1.push_back(pos);
      out1  = pq1.pop_front();
      orgb1 = pixel_of(out1);
      if (pos == FRAME - 1) frame = (frame + 1) % 65536;
      pos = (pos + 1) % FRAME;
    end
    if (en) begin
      fb2 = fb1;
      fb1 = a;
    end
  endtask

  // One pixel-clock cycle: drive inputs just after the edge, queue the
  // expectation for the mid-cycle sample, then advance the model.
  task automatic cycle(input logic r, input logic en);
    logic [15:0] a;
    rst       = r;
    pix_en    = en;
    vga_data0 = blank_mode ? 24'hFFFFFF : {fb2, 8'h5A};
    vga_data1 = blank_mode ? 24'hFFFFFF : {h_addr1, v_addr1, 8'h5A};
    if (model_ok) begin
      exp_q0.push_back(expect_obs(out0, orgb0, 1'b0, r, en));
      exp_q1.push_back(expect_obs(out1, orgb1, 1'b1, r, en));
    end
    @(negedge clk);
    a = {h_addr0, v_addr0};
    @(posedge clk);
    #2;
    model_edge(r, en, a);
  endtask

  // Monitor: compares whatever the driver queued for this cycle.
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        g = '{ha: h_addr0, va: v_addr0, rd: rd_en0, ls: ls0, fs: fs0, fc: fc0,
              hs: hsync0, vs: vsync0, vl: valid0, rgb: {r0, g0, b0}};
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL lat2 t=%0t got ha=%h va=%h rd=%b ls=%b fs=%b fc=%h hs=%b vs=%b vl=%b rgb=%h exp ha=%h va=%h rd=%b ls=%b fs=%b fc=%h hs=%b vs=%b vl=%b rgb=%h",
                   $time, g.ha, g.va, g.rd, g.ls, g.fs, g.fc, g.hs, g.vs, g.vl, g.rgb,
                   e.ha, e.va, e.rd, e.ls, e.fs, e.fc, e.hs, e.vs, e.vl, e.rgb);
        end
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        g = '{ha: h_addr1, va: v_addr1, rd: rd_en1, ls: ls1, fs: fs1, fc: fc1,
              hs: hsync1, vs: vsync1, vl: valid1, rgb: {r1, g1, b1}};
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL lat0 t=%0t got ha=%h va=%h rd=%b ls=%b fs=%b fc=%h hs=%b vs=%b vl=%b rgb=%h exp ha=%h va=%h rd=%b ls=%b fs=%b fc=%h hs=%b vs=%b vl=%b rgb=%h",
                   $time, g.ha, g.va, g.rd, g.ls, g.fs, g.fc, g.hs, g.vs, g.vl, g.rgb,
                   e.ha, e.va, e.rd, e.ls, e.fs, e.fc, e.hs, e.vs, e.vl, e.rgb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst       = 1'b1;
    pix_en    = 1'b0;
    vga_data0 = '0;
    vga_data1 = '0;
    fb1       = '0;
    fb2       = '0;
    @(posedge clk);
    #2;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);

    // Full rate, a little over two frames.
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1);

    // pix_en alternating: every output holds on disabled cycles.
    for (int i = 0; i < 300; i++) cycle(1'b0, (i % 2) == 0);

    // Constant white framebuffer: blanking must zero the colours.
    blank_mode = 1'b1;
    for (int i = 0; i < 150; i++) cycle(1'b0, 1'b1);
    blank_mode = 1'b0;

    // Random pixel enable.
    for (int i = 0; i < 400; i++) cycle(1'b0, $urandom_range(0, 3) != 0);

    // Mid-frame reset at h=5, v=2.
    guard = 0;
    while (pos != 2 * HT + 5 && guard < 2 * FRAME) begin
      cycle(1'b0, 1'b1);
      guard++;
    end
    tests++;
    if (pos != 2 * HT + 5) begin
      fails++;
      $display("FAIL reach_h5v2 got pos=%0d required pos=%0d", pos, 2 * HT + 5);
    end
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 200; i++) cycle(1'b0, 1'($urandom_range(0, 1)));

    // Reset while disabled, then release at full rate.
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
